mem_rdr: RTL

Read-side companion to the tester's 6-bit pattern register. It samples the register output on every write-ready strobe and queues the captured words in a small FIFO. It then hands them to the downstream checker over a valid/ready interface. It sits between the pattern register and the consumer logic so that back-to-back register writes are not lost while the consumer is stalled.

---
 rtl/mem_rdr_if.sv | 28 ++
 rtl/mem_rdr.sv | 90 +++++++++
 2 files changed

// File: rtl/mem_rdr_if.sv
// Handshake bundle between the pattern register, the mem_rdr FIFO and the downstream checker.
// master: the tester/consumer side that drives strobes and ready; slave: the mem_rdr FIFO.
interface mem_rdr_if #(
    parameter int DW    = 6,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] in_mem;
    logic          mem_wrt_rd;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          in_ready;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          in_clr_ovf;
    logic [7:0]    out_drop_cnt;

    modport master (
        output in_mem, mem_wrt_rd, in_ready, in_clr_ovf,
        input  out_data, out_valid, out_count, out_ovf, out_drop_cnt
    );

    modport slave (
        input  in_mem, mem_wrt_rd, in_ready, in_clr_ovf,
        output out_data, out_valid, out_count, out_ovf, out_drop_cnt
    );
endinterface

// File: rtl/mem_rdr.sv
// Captures the pattern register on each write-ready strobe into a show-ahead FIFO feeding a valid/ready consumer.
// Optional saturating drop counter is compiled in with `define MEM_RDR_DROP_CNT_EN.
module mem_rdr #(
    parameter int DW    = 6,
    parameter int DEPTH = 4
) (
    input logic      in_clk,
    input logic      in_rst_n,
    mem_rdr_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          ovf;

    // Extra pointer MSB separates full (same slot, other lap) from empty (identical pointers).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop     = !empty && bus.in_ready;
    assign push_ok = bus.mem_wrt_rd && (!full || pop);
    assign drop    = bus.mem_wrt_rd && full && !pop;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; only pointers decide what is valid.
    always_ff @(posedge in_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_mem;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (bus.in_clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef MEM_RDR_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturates at 255; a clear coinciding with a drop restarts the count at one.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop) begin
            if (bus.in_clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (bus.in_clr_ovf) begin
            drop_cnt <= 8'd0;
        end
    end

    assign bus.out_drop_cnt = drop_cnt;
`else
    assign bus.out_drop_cnt = 8'd0;
`endif

    assign bus.out_data  = mem[rd_ptr[AW-1:0]];
    assign bus.out_valid = !empty;
    assign bus.out_count = wr_ptr - rd_ptr;
    assign bus.out_ovf   = ovf;
endmodule
